imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time program loader that sits directly upstream of the CPU's instruction memory and PC.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words into IMEM at consecutive word addresses.
- Then drives SYS_load/SYS_pc_val to set the start PC and releases the CPU from hold.
- Replaces manual SYS_load/SYS_pc_val driving during bring-up.

Parameters:
IMEM_BASE, 32'h0000_0000, byte address of the first instruction word written
MAX_WORDS, 64, IMEM capacity in words; a larger header count is an error

Ports:
SYS_clk  in  1  system clock; all state updates on its rising edge
SYS_reset  in  1  synchronous, active-high reset
in_byte  in  8  stream byte
in_valid  in  1  in_byte is valid
in_ready  out  1  loader accepts a byte this cycle
rearm  in  1  one-cycle pulse in DONE: begin a new load
imem_we  out  1  IMEM write strobe, one cycle per word
imem_addr  out  32  IMEM byte address, word-aligned
imem_wdata  out  32  instruction word
SYS_load  out  1  one-cycle PC load pulse to the CPU
SYS_pc_val  out  32  start PC, valid while SYS_load=1 and held afterwards
cpu_hold  out  1  CPU clock-enable gate; 1 = CPU stalled
done  out  1  load completed successfully
err  out  1  sticky error flag

Behaviour:
- Reset, synchronous and active-high:
  - state=HDR_PC, byte counter=0, word index=0.
  - imem_we=0, SYS_load=0, SYS_pc_val=0, imem_addr=IMEM_BASE, imem_wdata=0.
  - cpu_hold=1, done=0, err=0.
  - in_ready=0 in any cycle where SYS_reset=1.
  - Reset mid-load aborts immediately. IMEM contents already written are left as-is.
- Handshake:
  - A byte is accepted when in_valid & in_ready at the clock edge.
  - in_ready = (state is HDR_PC, HDR_CNT or DATA) & !SYS_reset. It is combinational from state.
  - in_valid may drop at any time; the partial word/header is retained.
- Stream format, MSB byte first: 4 bytes start PC, 2 bytes word count N, then N x 4 bytes of instructions.
- HDR_PC: shift in 4 bytes. After the 4th byte:
  - If PC[1:0]!=0, go to ERR.
  - Otherwise latch the PC into SYS_pc_val and go to HDR_CNT.
- HDR_CNT: shift in 2 bytes, then decide:
  - N==0: go to LOAD.
  - N>MAX_WORDS: go to ERR.
  - Otherwise: go to DATA.
- DATA:
  - On acceptance of the 4th byte of word k, the next cycle has imem_we=1, imem_wdata=assembled word, imem_addr=IMEM_BASE+4*k.
  - Write latency is exactly 1 cycle after the last byte of the word.
  - Byte acceptance continues in the write cycle; there are no bubbles.
  - After the write of word N-1 is accepted, go to LOAD.
  - The last write cycle and the LOAD cycle are distinct: LOAD begins the cycle after imem_we for the last word.
- LOAD:
  - SYS_load=1 for exactly one cycle; SYS_pc_val = latched PC; cpu_hold remains 1.
  - Next state: DONE.
- DONE:
  - cpu_hold=0, done=1, in_ready=0.
  - Bytes presented here are not accepted.
  - rearm=1 goes to HDR_PC: cpu_hold=1 and done=0 on the next cycle, counters cleared.
- ERR: err=1, cpu_hold=1, in_ready=0, no further writes. Exit only via SYS_reset.
- Width rules:
  - Word index is ceil(log2(MAX_WORDS+1)) bits.
  - Address arithmetic is 32-bit modulo 2^32; no wrap check.
- imem_we is never asserted outside DATA/write-cycle timing; SYS_load is never asserted outside LOAD.

Decomposition:
- Shared package holds:
  - the state enum (HDR_PC, HDR_CNT, DATA, LOAD, DONE, ERR);
  - constants PC_BYTES=4, CNT_BYTES=2, WORD_BYTES=4.
- One sub-module, byte_assembler: 32-bit shift register plus 2-bit byte counter with load/clear. It flags when a 4th byte (or the 2nd byte in count mode) is accepted.
- The FSM, address generator and output registers stay in imem_loader.

Test Plan:
1. Nominal load:
   - Stimulus: stream 00 00 00 08 | 00 02 | 20 08 00 05 | 01 09 50 20, in_valid always 1.
   - Required: writes 32'h20080005 @0x0 and 32'h01095020 @0x4, each 1 cycle after the word's last byte. SYS_load pulse with SYS_pc_val=0x8, then cpu_hold=0, done=1.
2. Gappy valid:
   - Stimulus: same stream with in_valid=0 for 3 cycles inside every word.
   - Required: identical IMEM writes and addresses; no spurious imem_we.
3. Zero count:
   - Stimulus: header PC=0x10, N=0.
   - Required: no imem_we; SYS_load the cycle after the 2nd count byte; done=1.
4. Errors:
   - Stimulus A: PC=0x6. Required: err=1 after the 4th header byte, in_ready=0, cpu_hold=1.
   - Stimulus B: N=65 with MAX_WORDS=64. Required: err=1 and no writes.
5. Reset mid-DATA:
   - Stimulus: assert SYS_reset after 5 data bytes.
   - Required: all outputs at reset values next cycle. A subsequent full stream loads correctly from word 0.
6. Rearm:
   - Stimulus: after DONE, pulse rearm and stream a second program (PC=0x0, N=1, word 32'hFFFFFFFF).
   - Required: cpu_hold returns to 1; write 32'hFFFFFFFF @0x0; second SYS_load pulse.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the boot-time IMEM loader.
// Pure declarations: no latency, no flow control.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_PC  = 3'd0,
    HDR_CNT = 3'd1,
    DATA    = 3'd2,
    LOAD    = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam int PC_BYTES   = 4;
  localparam int CNT_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Big-endian byte shifter: flags the 4th byte (2nd in count mode) combinationally with the
// full assembled value; state updates only on shift, so the caller owns all backpressure.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift,
  input  logic        cnt_mode,
  input  logic [7:0]  in_byte,
  output logic [31:0] assembled,
  output logic        last
);

  logic [31:0] word_q;
  logic [1:0]  cnt;
  logic [1:0]  target;

  // The value presented includes the byte being accepted this cycle.
  assign assembled = {word_q[23:0], in_byte};
  assign target    = cnt_mode ? 2'(CNT_BYTES - 1) : 2'(PC_BYTES - 1);
  assign last      = shift && (cnt == target);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_q <= '0;
      cnt    <= '0;
    end else if (shift) begin
      word_q <= assembled;
      cnt    <= last ? 2'd0 : cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses PC/count header, writes words to IMEM 1 cycle after each last byte,
// then pulses SYS_load and releases cpu_hold; in_ready drops outside header/data phases.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        rearm,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        SYS_load,
  output logic [31:0] SYS_pc_val,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  state_t             state;
  logic [IDX_W-1:0]   widx;
  logic [IDX_W-1:0]   cnt_n;
  logic               last_wr;
  logic [31:0]        asm_word;
  logic               asm_last;
  logic               asm_shift;
  logic               asm_clear;

  assign in_ready  = (state == HDR_PC || state == HDR_CNT || state == DATA) && !SYS_reset;
  // During the final write cycle the stream is complete; a byte taken then is discarded.
  assign asm_shift = in_valid && in_ready && !(state == DATA && last_wr);
  assign asm_clear = (state == DONE) && rearm;

  imem_loader_byte_assembler u_asm (
    .clk       (SYS_clk),
    .rst       (SYS_reset),
    .clear     (asm_clear),
    .shift     (asm_shift),
    .cnt_mode  (state == HDR_CNT),
    .in_byte   (in_byte),
    .assembled (asm_word),
    .last      (asm_last)
  );

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state      <= HDR_PC;
      widx       <= '0;
      cnt_n      <= '0;
      last_wr    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= IMEM_BASE;
      imem_wdata <= '0;
      SYS_load   <= 1'b0;
      SYS_pc_val <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we  <= 1'b0;
      SYS_load <= 1'b0;
      case (state)
        HDR_PC: begin
          if (asm_last) begin
            if (asm_word[1:0] != 2'b00) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              SYS_pc_val <= asm_word;
              state      <= HDR_CNT;
            end
          end
        end
        HDR_CNT: begin
          if (asm_last) begin
            if (asm_word[15:0] == 16'd0) begin
              state    <= LOAD;
              SYS_load <= 1'b1;
            end else if (asm_word[15:0] > 16'(MAX_WORDS)) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              cnt_n <= asm_word[IDX_W-1:0];
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (last_wr) begin
            last_wr  <= 1'b0;
            state    <= LOAD;
            SYS_load <= 1'b1;
          end else if (asm_last) begin
            imem_we    <= 1'b1;
            imem_wdata <= asm_word;
            imem_addr  <= IMEM_BASE + 32'(widx) * 32'(WORD_BYTES);
            widx       <= widx + IDX_W'(1);
            if (widx + IDX_W'(1) == cnt_n) last_wr <= 1'b1;
          end
        end
        LOAD: begin
          state    <= DONE;
          cpu_hold <= 1'b0;
          done     <= 1'b1;
        end
        DONE: begin
          if (rearm) begin
            state    <= HDR_PC;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            widx     <= '0;
            cnt_n    <= '0;
          end
        end
        ERR: ;
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream-position reference model checked every cycle, plus
// literal expectations on the write log and load pulses for each directed scenario.
module tb_imem_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        SYS_reset = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        rearm = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic        SYS_load;
  logic [31:0] SYS_pc_val;
  logic        cpu_hold, done, err;

  imem_loader dut (
    .SYS_clk(clk), .SYS_reset(SYS_reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .rearm(rearm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .SYS_load(SYS_load), .SYS_pc_val(SYS_pc_val),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Reference model: tracks position in the byte stream and derives outputs from it.
  localparam int M_RX = 0, M_LASTW = 1, M_LOAD = 2, M_DONE = 3, M_ERR = 4;
  localparam int MAXW = 64;
  int          mode = M_RX;
  int          pos = 0;
  int          n_words = 0;
  logic [31:0] sh = '0;
  logic        e_we = 0, e_load = 0, e_hold = 1, e_done = 0, e_err = 0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_pc = '0;
  bit          chk_en = 0;

  function automatic logic model_ready();
    return (mode == M_RX || mode == M_LASTW) && !SYS_reset;
  endfunction

  always @(posedge clk) begin
    int k;
    if (SYS_reset) begin
      mode = M_RX; pos = 0; n_words = 0; sh = '0;
      e_we = 0; e_load = 0; e_hold = 1; e_done = 0; e_err = 0;
      e_addr = '0; e_wdata = '0; e_pc = '0;
      chk_en = 1;
    end else begin
      e_we = 0; e_load = 0;
      case (mode)
        M_RX: if (in_valid) begin
          sh = {sh[23:0], in_byte};
          pos++;
          if (pos == 4) begin
            if (sh[1:0] != 2'b00) begin mode = M_ERR; e_err = 1; end
            else e_pc = sh;
          end else if (pos == 6) begin
            n_words = int'(sh[15:0]);
            if (n_words == 0) begin mode = M_LOAD; e_load = 1; end
            else if (n_words > MAXW) begin mode = M_ERR; e_err = 1; end
          end else if (pos > 6 && (pos - 6) % 4 == 0) begin
            k = (pos - 6) / 4 - 1;
            e_we = 1; e_addr = 32'(4 * k); e_wdata = sh;
            if (k == n_words - 1) mode = M_LASTW;
          end
        end
        M_LASTW: begin mode = M_LOAD; e_load = 1; end
        M_LOAD:  begin mode = M_DONE; e_hold = 0; e_done = 1; end
        M_DONE:  if (rearm) begin mode = M_RX; pos = 0; e_hold = 1; e_done = 0; end
        default: ;
      endcase
    end
  end

  logic [63:0] wq[$];
  int          ld_cnt = 0;
  logic [31:0] ld_pc = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(model_ready()));
      check("imem_we", 32'(imem_we), 32'(e_we));
      check("imem_addr", imem_addr, e_addr);
      check("imem_wdata", imem_wdata, e_wdata);
      check("SYS_load", 32'(SYS_load), 32'(e_load));
      check("SYS_pc_val", SYS_pc_val, e_pc);
      check("cpu_hold", 32'(cpu_hold), 32'(e_hold));
      check("done", 32'(done), 32'(e_done));
      check("err", 32'(err), 32'(e_err));
      if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});
      if (SYS_load === 1'b1) begin ld_cnt++; ld_pc = SYS_pc_val; end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 0;
    int guard = 0;
    in_byte = b; in_valid = 1'b1;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; guard++;
    end while (!acc && guard < 50);
    if (!acc) check("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input byte_q_t s, input bit gappy);
    for (int i = 0; i < s.size(); i++) begin
      if (gappy && i >= 6 && (i - 6) % 4 == 2) tick(3);
      send_byte(s[i]);
    end
  endtask

  task automatic wait_done();
    int guard = 0;
    while (done !== 1'b1 && guard < 20) begin tick(1); guard++; end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1; tick(1); rearm = 1'b0;
  endtask

  byte_q_t nominal, prog2, zero_cnt, bad_pc, big_cnt, partial;

  initial begin
    nominal  = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h02,
                 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    prog2    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    zero_cnt = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
    bad_pc   = '{8'h00, 8'h00, 8'h00, 8'h06};
    big_cnt  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h41};
    partial  = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01};

    tick(2);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    SYS_reset = 1'b0;
    tick(1);

    // Nominal load.
    wq.delete();
    send_stream(nominal, 0);
    wait_done();
    check("t1_nwr", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      check("t1_w0", wq[0][31:0], 32'h2008_0005);
      check("t1_a0", wq[0][63:32], 32'h0);
      check("t1_w1", wq[1][31:0], 32'h0109_5020);
      check("t1_a1", wq[1][63:32], 32'h4);
    end
    check("t1_ld", 32'(ld_cnt), 32'd1);
    check("t1_pc", ld_pc, 32'h8);
    check("t1_hold", 32'(cpu_hold), 32'd0);

    // Bytes offered in DONE must be refused.
    in_valid = 1'b1; in_byte = 8'hAA; tick(3); in_valid = 1'b0;

    // Rearm with second program.
    wq.delete();
    pulse_rearm();
    check("t6_hold", 32'(cpu_hold), 32'd1);
    send_stream(prog2, 0);
    wait_done();
    check("t6_nwr", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) check("t6_w0", wq[0], {32'h0, 32'hFFFF_FFFF});
    check("t6_ld", 32'(ld_cnt), 32'd2);

    // Gappy valid.
    wq.delete();
    pulse_rearm();
    send_stream(nominal, 1);
    wait_done();
    check("t2_nwr", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      check("t2_w0", wq[0], {32'h0, 32'h2008_0005});
      check("t2_w1", wq[1], {32'h4, 32'h0109_5020});
    end

    // Zero count.
    wq.delete();
    pulse_rearm();
    send_stream(zero_cnt, 0);
    check("t3_load_now", 32'(SYS_load), 32'd1);
    wait_done();
    check("t3_nwr", 32'(wq.size()), 32'd0);
    check("t3_pc", ld_pc, 32'h10);

    // Misaligned PC.
    pulse_rearm();
    send_stream(bad_pc, 0);
    check("t4a_err", 32'(err), 32'd1);
    check("t4a_ready", 32'(in_ready), 32'd0);
    tick(3);
    check("t4a_hold", 32'(cpu_hold), 32'd1);
    SYS_reset = 1'b1; tick(1); SYS_reset = 1'b0;
    check("t4a_clr", 32'(err), 32'd0);

    // Oversized count.
    wq.delete();
    send_stream(big_cnt, 0);
    in_valid = 1'b1; in_byte = 8'h55; tick(4); in_valid = 1'b0;
    check("t4b_err", 32'(err), 32'd1);
    check("t4b_nwr", 32'(wq.size()), 32'd0);
    SYS_reset = 1'b1; tick(1); SYS_reset = 1'b0;

    // Reset mid-DATA, then a clean reload.
    send_stream(partial, 0);
    SYS_reset = 1'b1; tick(1);
    check("t5_we", 32'(imem_we), 32'd0);
    check("t5_pc", SYS_pc_val, 32'h0);
    check("t5_addr", imem_addr, 32'h0);
    SYS_reset = 1'b0;
    wq.delete();
    send_stream(nominal, 0);
    wait_done();
    check("t5_nwr", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      check("t5_w0", wq[0], {32'h0, 32'h2008_0005});
      check("t5_w1", wq[1], {32'h4, 32'h0109_5020});
    end
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
